// File: rtl/ball_physics.sv
// Per-ball motion engine: fixed-point position integration, shots, collisions and pocketing.
// Optional friction decay is enabled by defining BALL_PHYSICS_FRICTION_EN.
module ball_physics #(
  parameter int INIT_X          = 100,
  parameter int INIT_Y          = 200,
  parameter int FRAC_BITS       = 4,
  parameter int MAX_VEL         = 255,
  parameter int COOLDOWN_FRAMES = 3
`ifdef BALL_PHYSICS_FRICTION_EN
  , parameter int FRICTION_PERIOD = 4
`endif
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collisionOccurred,
  input  logic signed [10:0] velXIn,
  input  logic signed [10:0] velYIn,
  input  logic               holeHit,
  input  logic               shotValid,
  input  logic signed [10:0] shotVelX,
  input  logic signed [10:0] shotVelY,
  input  logic               respawn,
  output logic [10:0]        topLeftPosX,
  output logic [10:0]        topLeftPosY,
  output logic signed [10:0] velX,
  output logic signed [10:0] velY,
  output logic               ballMoving,
  output logic               ballInHole
);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVING = 2'd1, IN_HOLE = 2'd2} state_t;

  localparam int PW = 11 + FRAC_BITS;
  localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [PW-1:0] INIT_PX = PW'(INIT_X) << FRAC_BITS;
  localparam logic [PW-1:0] INIT_PY = PW'(INIT_Y) << FRAC_BITS;
  localparam logic signed [10:0] VMAX = 11'(MAX_VEL);
  localparam logic [CW-1:0] CD_INIT = CW'(COOLDOWN_FRAMES);

  state_t              state;
  logic [PW-1:0]       pos_x, pos_y;
  logic signed [10:0]  pend_x, pend_y;
  logic                pending, pend_coll;
  logic [CW-1:0]       cooldown;

  logic signed [10:0]  base_x, base_y, vel_nx, vel_ny;
  logic [PW-1:0]       pos_nx, pos_ny;
  logic                vel_zero, accept_coll, accept_shot;

  function automatic logic signed [10:0] sat(input logic signed [10:0] v);
    if (v > VMAX)       return VMAX;
    else if (v < -VMAX) return -VMAX;
    else                return v;
  endfunction

  // Position is unsigned; a signed two-bit-wider sum detects both underflow and overflow.
  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p, input logic signed [10:0] v);
    logic signed [PW+1:0] s;
    s = $signed({2'b00, p}) + $signed({{(PW-9){v[10]}}, v});
    if (s[PW+1])  return '0;
    else if (s[PW]) return '1;
    else          return s[PW-1:0];
  endfunction

`ifdef BALL_PHYSICS_FRICTION_EN
  localparam int FW = (FRICTION_PERIOD < 2) ? 1 : $clog2(FRICTION_PERIOD);
  logic [FW-1:0] fric_cnt;
  logic          fric_wrap;

  function automatic logic signed [10:0] fric(input logic signed [10:0] v);
    if (v == 11'sd0)  return v;
    else if (v[10])   return v + 11'sd1;
    else              return v - 11'sd1;
  endfunction

  assign fric_wrap = (fric_cnt == FW'(FRICTION_PERIOD - 1));
`endif

  always_comb begin
    base_x = velX;
    base_y = velY;
    if (pending) begin
      base_x = pend_x;
      base_y = pend_y;
    end
`ifdef BALL_PHYSICS_FRICTION_EN
    else if (fric_wrap) begin
      base_x = fric(velX);
      base_y = fric(velY);
    end
`endif
    vel_nx = sat(base_x);
    vel_ny = sat(base_y);
    pos_nx = step_pos(pos_x, vel_nx);
    pos_ny = step_pos(pos_y, vel_ny);
  end

  assign vel_zero    = (vel_nx == 11'sd0) && (vel_ny == 11'sd0);
  assign accept_coll = collisionOccurred && !pending && (cooldown == '0) &&
                       (state != IN_HOLE) && !holeHit;
  assign accept_shot = shotValid && (state == IDLE) && !pending && !accept_coll && !holeHit;

  assign topLeftPosX = pos_x[PW-1:FRAC_BITS];
  assign topLeftPosY = pos_y[PW-1:FRAC_BITS];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      pos_x      <= INIT_PX;
      pos_y      <= INIT_PY;
      velX       <= '0;
      velY       <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pending    <= 1'b0;
      pend_coll  <= 1'b0;
      cooldown   <= '0;
      ballMoving <= 1'b0;
      ballInHole <= 1'b0;
`ifdef BALL_PHYSICS_FRICTION_EN
      fric_cnt   <= '0;
`endif
    end else begin
      case (state)
        IN_HOLE: begin
          if (respawn) begin
            state      <= IDLE;
            pos_x      <= INIT_PX;
            pos_y      <= INIT_PY;
            velX       <= '0;
            velY       <= '0;
            pending    <= 1'b0;
            pend_coll  <= 1'b0;
            cooldown   <= '0;
            ballMoving <= 1'b0;
            ballInHole <= 1'b0;
`ifdef BALL_PHYSICS_FRICTION_EN
            fric_cnt   <= '0;
`endif
          end
        end
        default: begin
          if (holeHit) begin
            state      <= IN_HOLE;
            velX       <= '0;
            velY       <= '0;
            pending    <= 1'b0;
            pend_coll  <= 1'b0;
            ballMoving <= 1'b0;
            ballInHole <= 1'b1;
          end else begin
            if (startOfFrame) begin
              velX       <= vel_nx;
              velY       <= vel_ny;
              pos_x      <= pos_nx;
              pos_y      <= pos_ny;
              pending    <= 1'b0;
              pend_coll  <= 1'b0;
              state      <= vel_zero ? IDLE : MOVING;
              ballMoving <= !vel_zero;
              if (pending && pend_coll) cooldown <= CD_INIT;
              else if (cooldown != '0)  cooldown <= cooldown - 1'b1;
`ifdef BALL_PHYSICS_FRICTION_EN
              if (pending || fric_wrap) fric_cnt <= '0;
              else                      fric_cnt <= fric_cnt + 1'b1;
`endif
            end
            // Events in the update cycle land in the freshly emptied slot for the next frame.
            if (accept_coll) begin
              pend_x    <= velXIn;
              pend_y    <= velYIn;
              pending   <= 1'b1;
              pend_coll <= 1'b1;
            end else if (accept_shot) begin
              pend_x    <= shotVelX;
              pend_y    <= shotVelY;
              pending   <= 1'b1;
              pend_coll <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_physics.sv
// Self-checking bench for ball_physics: scenario tasks with an expected-value queue.
// Friction scenario runs only when BALL_PHYSICS_FRICTION_EN is defined.
module tb_ball_physics;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               collisionOccurred;
  logic signed [10:0] velXIn, velYIn;
  logic               holeHit;
  logic               shotValid;
  logic signed [10:0] shotVelX, shotVelY;
  logic               respawn;
  logic [10:0]        topLeftPosX, topLeftPosY;
  logic signed [10:0] velX, velY;
  logic               ballMoving, ballInHole;

  int          errors = 0;
  int          checks = 0;
  logic [45:0] exp_q[$];
  logic [45:0] e;

  ball_physics dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .collisionOccurred(collisionOccurred), .velXIn(velXIn), .velYIn(velYIn),
    .holeHit(holeHit), .shotValid(shotValid), .shotVelX(shotVelX), .shotVelY(shotVelY),
    .respawn(respawn), .topLeftPosX(topLeftPosX), .topLeftPosY(topLeftPosY),
    .velX(velX), .velY(velY), .ballMoving(ballMoving), .ballInHole(ballInHole)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [45:0] pk(input int x, input int y, input int vx, input int vy,
                                     input int m, input int h);
    return {11'(x), 11'(y), 11'(vx), 11'(vy), 1'(m), 1'(h)};
  endfunction

  function automatic logic [45:0] cur();
    return {topLeftPosX, topLeftPosY, velX, velY, ballMoving, ballInHole};
  endfunction

  function automatic string fmt(input logic [45:0] v);
    return $sformatf("pos=(%0d,%0d) vel=(%0d,%0d) moving=%0b hole=%0b",
                     v[45:35], v[34:24], $signed(v[23:13]), $signed(v[12:2]), v[1], v[0]);
  endfunction

  // Stimulus driven on the falling edge; DUT outputs sampled on the following falling edge.
  task automatic idle_inputs();
    startOfFrame = 0; collisionOccurred = 0; velXIn = 0; velYIn = 0; holeHit = 0;
    shotValid = 0; shotVelX = 0; shotVelY = 0; respawn = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    exp_q.delete();
    @(negedge clk); resetN = 0;
    repeat (2) @(negedge clk);
    resetN = 1;
    @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk); startOfFrame = 1;
    @(negedge clk); startOfFrame = 0;
  endtask

  task automatic shot(input int vx, input int vy);
    @(negedge clk); shotValid = 1; shotVelX = 11'(vx); shotVelY = 11'(vy);
    @(negedge clk); shotValid = 0;
  endtask

  task automatic collide(input int vx, input int vy);
    @(negedge clk); collisionOccurred = 1; velXIn = 11'(vx); velYIn = 11'(vy);
    @(negedge clk); collisionOccurred = 0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_q.push_back(pk(100, 200, 0, 0, 0, 0));
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL reset: got %s, expected %s", fmt(cur()), fmt(e)); end
    // Reset mid-frame with a pending shot must discard it.
    shot(64, 64);
    #2 resetN = 0;
    #1 exp_q.push_back(pk(100, 200, 0, 0, 0, 0));
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL reset_async: got %s, expected %s", fmt(cur()), fmt(e)); end
    @(negedge clk); resetN = 1;
    exp_q.push_back(pk(100, 200, 0, 0, 0, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL reset_pending_dropped: got %s, expected %s", fmt(cur()), fmt(e)); end
  endtask

  task automatic test_shot();
    do_reset();
    shot(32, -16);
    exp_q.push_back(pk(102, 199, 32, -16, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL shot_first: got %s, expected %s", fmt(cur()), fmt(e)); end
    exp_q.push_back(pk(104, 198, 32, -16, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL shot_second: got %s, expected %s", fmt(cur()), fmt(e)); end
    shot(5, 5);
    exp_q.push_back(pk(106, 197, 32, -16, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL shot_while_moving: got %s, expected %s", fmt(cur()), fmt(e)); end
  endtask

  task automatic test_collision();
    int x;
    do_reset();
    shot(32, 0);
    exp_q.push_back(pk(102, 200, 32, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL coll_setup: got %s, expected %s", fmt(cur()), fmt(e)); end
    collide(-48, 0);
    collide(-64, 0);
    exp_q.push_back(pk(99, 200, -48, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL coll_first_wins: got %s, expected %s", fmt(cur()), fmt(e)); end
    x = 99;
    for (int i = 0; i < 3; i++) begin
      collide(16, 0);
      x = x - 3;
      exp_q.push_back(pk(x, 200, -48, 0, 1, 0));
      frame();
      e = exp_q.pop_front(); checks++;
      if (cur() !== e) begin errors++; $display("FAIL coll_cooldown%0d: got %s, expected %s", i, fmt(cur()), fmt(e)); end
    end
    collide(16, 0);
    exp_q.push_back(pk(x + 1, 200, 16, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL coll_after_cooldown: got %s, expected %s", fmt(cur()), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    shot(16, 0);
    frame();
    // Collision coinciding with the update strobe is applied one frame later.
    @(negedge clk); startOfFrame = 1; collisionOccurred = 1; velXIn = -32; velYIn = 0;
    @(negedge clk); startOfFrame = 0; collisionOccurred = 0;
    exp_q.push_back(pk(102, 200, 16, 0, 1, 0));
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL b2b_same_cycle: got %s, expected %s", fmt(cur()), fmt(e)); end
    exp_q.push_back(pk(100, 200, -32, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL b2b_next_frame: got %s, expected %s", fmt(cur()), fmt(e)); end
  endtask

  task automatic test_hole();
    do_reset();
    shot(16, 0);
    exp_q.push_back(pk(101, 200, 16, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL hole_setup: got %s, expected %s", fmt(cur()), fmt(e)); end
    @(negedge clk); holeHit = 1; collisionOccurred = 1; velXIn = 500; velYIn = 7;
    @(negedge clk); holeHit = 0; collisionOccurred = 0;
    exp_q.push_back(pk(101, 200, 0, 0, 0, 1));
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL hole_entry: got %s, expected %s", fmt(cur()), fmt(e)); end
    shot(40, 40);
    collide(80, 80);
    exp_q.push_back(pk(101, 200, 0, 0, 0, 1));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL hole_ignores_events: got %s, expected %s", fmt(cur()), fmt(e)); end
    @(negedge clk); respawn = 1;
    @(negedge clk); respawn = 0;
    exp_q.push_back(pk(100, 200, 0, 0, 0, 0));
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL hole_respawn: got %s, expected %s", fmt(cur()), fmt(e)); end
    exp_q.push_back(pk(100, 200, 0, 0, 0, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL hole_respawn_idle: got %s, expected %s", fmt(cur()), fmt(e)); end
  endtask

  task automatic test_saturation();
    do_reset();
    shot(250, 0);
    exp_q.push_back(pk(115, 200, 250, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL sat_setup: got %s, expected %s", fmt(cur()), fmt(e)); end
    collide(1000, 0);
    exp_q.push_back(pk(131, 200, 255, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL sat_pos_vel: got %s, expected %s", fmt(cur()), fmt(e)); end
    repeat (150) frame();
    checks++;
    if (topLeftPosX !== 11'd2047) begin errors++; $display("FAIL sat_clamp_high: got x=%0d, expected x=2047", topLeftPosX); end
    collide(-1000, 0);
    exp_q.push_back(pk(2032, 200, -255, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL sat_neg: got %s, expected %s", fmt(cur()), fmt(e)); end
    repeat (150) frame();
    checks++;
    if (topLeftPosX !== 11'd0) begin errors++; $display("FAIL sat_clamp_low: got x=%0d, expected x=0", topLeftPosX); end
  endtask

  task automatic test_random();
    int vx, vy;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      vx = int'($urandom_range(400, 0)) - 200;
      vy = int'($urandom_range(400, 0)) - 200;
      shot(vx, vy);
      exp_q.push_back(pk((1600 + vx) / 16, (3200 + vy) / 16, vx, vy,
                         (vx != 0 || vy != 0) ? 1 : 0, 0));
      frame();
      e = exp_q.pop_front(); checks++;
      if (cur() !== e) begin errors++; $display("FAIL random%0d: got %s, expected %s", i, fmt(cur()), fmt(e)); end
    end
  endtask

`ifdef BALL_PHYSICS_FRICTION_EN
  task automatic test_friction();
    do_reset();
    shot(2, 0);
    frame();
    repeat (3) frame();
    exp_q.push_back(pk(100, 200, 1, 0, 1, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL friction_step1: got %s, expected %s", fmt(cur()), fmt(e)); end
    repeat (3) frame();
    exp_q.push_back(pk(100, 200, 0, 0, 0, 0));
    frame();
    e = exp_q.pop_front(); checks++;
    if (cur() !== e) begin errors++; $display("FAIL friction_stop: got %s, expected %s", fmt(cur()), fmt(e)); end
  endtask
`endif

  initial begin
    resetN = 1;
    idle_inputs();
    test_reset();
    test_shot();
    test_collision();
    test_back_to_back();
    test_hole();
    test_saturation();
    test_random();
`ifdef BALL_PHYSICS_FRICTION_EN
    test_friction();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
